sat_clause_sequencer: RTL and testbench

SAT_CLAUSE_SEQUENCER -- requirements
Module: sat_clause_sequencer

---
 rtl/sat_clause_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_sat_clause_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sat_clause_sequencer.sv
// rtl/sat_clause_sequencer.sv - clause-table sequencer issuing INIT/LIT/COMMIT/HOLD commands to a CNF accelerator
// Walks literal-pair entries, closes a clause on 'last' or table end, then waits for and captures the result.
module sat_clause_sequencer #(
   parameter int MAX_ENTRIES = 32,
   parameter int RESULT_LAT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [12:0] wr_data,
   input  logic        start,
   input  logic [5:0]  num_entries,
   input  logic        outCNF,
   output logic [1:0]  stateVal,
   output logic [4:0]  varPos1,
   output logic [4:0]  varPos2,
   output logic        negCtrl1,
   output logic        negCtrl2,
   output logic        busy,
   output logic        done,
   output logic        sat,
   output logic [5:0]  clause_cnt
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_INIT   = 3'd1;
   localparam logic [2:0] S_LIT    = 3'd2;
   localparam logic [2:0] S_COMMIT = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic [1:0] CMD_INIT   = 2'b00;
   localparam logic [1:0] CMD_LIT    = 2'b01;
   localparam logic [1:0] CMD_COMMIT = 2'b10;
   localparam logic [1:0] CMD_HOLD   = 2'b11;

   localparam logic [5:0] MAX_N      = 6'(MAX_ENTRIES);
   localparam logic [2:0] DRAIN_LAST = 3'(RESULT_LAT - 1);

   logic [12:0] table_mem [MAX_ENTRIES];

   logic [2:0]  state_q, state_d;
   logic [5:0]  ptr_q, ptr_d;
   logic [5:0]  n_q, n_d;
   logic [2:0]  drain_q, drain_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        sat_q, sat_d;
   logic [1:0]  sv_q, sv_d;
   logic [4:0]  var1_q, var1_d, var2_q, var2_d;
   logic        neg1_q, neg1_d, neg2_q, neg2_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [5:0]  ptr_inc;
   logic [12:0] cur_entry, next_entry, lit_entry;

   assign ptr_inc    = ptr_q + 6'd1;
   assign cur_entry  = table_mem[ptr_q[4:0]];
   assign next_entry = table_mem[ptr_inc[4:0]];

   // Table is only writable while idle, so LIT reads never race a write.
   always_ff @(posedge clk) begin
      if (!reset && wr_en && !busy_q) begin
         table_mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      n_d       = n_q;
      drain_d   = drain_q;
      cnt_d     = cnt_q;
      sat_d     = sat_q;
      lit_entry = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_INIT;
               n_d     = (num_entries > MAX_N) ? MAX_N : num_entries;
               ptr_d   = '0;
               cnt_d   = '0;
            end
         end
         S_INIT: begin
            if (n_q != 6'd0) begin
               state_d   = S_LIT;
               lit_entry = cur_entry;
            end else begin
               state_d = S_DRAIN;
               drain_d = '0;
            end
         end
         S_LIT: begin
            ptr_d = ptr_inc;
            if (cur_entry[12] || (ptr_q == n_q - 6'd1)) begin
               state_d = S_COMMIT;
            end else begin
               state_d   = S_LIT;
               lit_entry = next_entry;
            end
         end
         S_COMMIT: begin
            cnt_d = cnt_q + 6'd1;
            if (ptr_q < n_q) begin
               state_d   = S_LIT;
               lit_entry = cur_entry;
            end else begin
               state_d = S_DRAIN;
               drain_d = '0;
            end
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               state_d = S_DONE;
               sat_d   = outCNF;
            end else begin
               drain_d = drain_q + 3'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state they describe.
   always_comb begin
      sv_d   = CMD_HOLD;
      var1_d = '0;
      var2_d = '0;
      neg1_d = 1'b0;
      neg2_d = 1'b0;
      case (state_d)
         S_INIT:   sv_d = CMD_INIT;
         S_LIT: begin
            sv_d   = CMD_LIT;
            neg2_d = lit_entry[11];
            var2_d = lit_entry[10:6];
            neg1_d = lit_entry[5];
            var1_d = lit_entry[4:0];
         end
         S_COMMIT: sv_d = CMD_COMMIT;
         default:  sv_d = CMD_HOLD;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         n_q     <= '0;
         drain_q <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         sv_q    <= CMD_HOLD;
         var1_q  <= '0;
         var2_q  <= '0;
         neg1_q  <= 1'b0;
         neg2_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         n_q     <= n_d;
         drain_q <= drain_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         sv_q    <= sv_d;
         var1_q  <= var1_d;
         var2_q  <= var2_d;
         neg1_q  <= neg1_d;
         neg2_q  <= neg2_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign stateVal   = sv_q;
   assign varPos1    = var1_q;
   assign varPos2    = var2_q;
   assign negCtrl1   = neg1_q;
   assign negCtrl2   = neg2_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign sat        = sat_q;
   assign clause_cnt = cnt_q;

endmodule

// File: tb/tb_sat_clause_sequencer.sv
// tb/tb_sat_clause_sequencer.sv - scoreboard bench for sat_clause_sequencer
// Stimulus pushes per-cycle expected command records; a negedge monitor pops them while busy.
module tb_sat_clause_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [12:0] wr_data;
   logic        start;
   logic [5:0]  num_entries;
   logic        outCNF;
   logic [1:0]  stateVal;
   logic [4:0]  varPos1, varPos2;
   logic        negCtrl1, negCtrl2;
   logic        busy, done, sat;
   logic [5:0]  clause_cnt;

   always #5 clk = ~clk;

   sat_clause_sequencer #(.MAX_ENTRIES(32), .RESULT_LAT(2)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .num_entries(num_entries), .outCNF(outCNF),
      .stateVal(stateVal), .varPos1(varPos1), .varPos2(varPos2),
      .negCtrl1(negCtrl1), .negCtrl2(negCtrl2), .busy(busy), .done(done),
      .sat(sat), .clause_cnt(clause_cnt)
   );

   typedef struct packed {
      logic [1:0] sv;
      logic [4:0] v1;
      logic       n1;
      logic [4:0] v2;
      logic       n2;
      logic       dn;
      logic [5:0] cnt;
      logic       st;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   function automatic void push(input logic [1:0] sv, input logic [4:0] v1 = 0, input logic n1 = 0,
                                input logic [4:0] v2 = 0, input logic n2 = 0, input logic dn = 0,
                                input logic [5:0] cnt = 0, input logic st = 0);
      exp_q.push_back('{sv, v1, n1, v2, n2, dn, cnt, st});
   endfunction

   always @(negedge clk) begin
      if (busy === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_busy_cycle", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("cycle_outputs", {stateVal, varPos1, negCtrl1, varPos2, negCtrl2, done},
                  {mon_e.sv, mon_e.v1, mon_e.n1, mon_e.v2, mon_e.n2, mon_e.dn});
            if (mon_e.dn) begin
               check("done_clause_cnt", clause_cnt, mon_e.cnt);
               check("done_sat", sat, mon_e.st);
            end
         end
      end else if (busy === 1'b0) begin
         check("done_without_busy", done, 1'b0);
      end
   end

   task automatic wr(input logic [4:0] a, input logic [12:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   // Issues start (with any pre-set wr_en) and waits for done; optionally injects a busy write+start.
   task automatic run(input logic [5:0] num, input logic cnf, input int exp_lat, input int inject_at);
      int  n;
      logic got;
      n = 0; got = 1'b0;
      outCNF = cnf; num_entries = num; start = 1'b1;
      while (n < 200 && !got) begin
         @(posedge clk); #1;
         start = 1'b0; wr_en = 1'b0;
         n++;
         if (done) got = 1'b1;
         else if (n == inject_at) begin
            wr_en = 1'b1; wr_addr = 5'd0; wr_data = 13'h1fff; start = 1'b1; num_entries = 6'd1;
         end
      end
      if (got) check("start_to_done_latency", n, exp_lat);
      else check("done_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      check("busy_after_done", busy, 1'b0);
      check("queue_drained", exp_q.size(), 0);
      if (!got) exp_q.delete();
   endtask

   task automatic expect_main(input logic st);
      push(2'b00);
      push(2'b01, 5'd2, 1'b1, 5'd3, 1'b0);
      push(2'b01, 5'd5, 1'b0, 5'd4, 1'b0);
      push(2'b10);
      push(2'b01, 5'd7, 1'b0, 5'd7, 1'b1);
      push(2'b10);
      push(2'b11);
      push(2'b11);
      push(2'b11, 0, 0, 0, 0, 1'b1, 6'd2, st);
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; num_entries = '0; outCNF = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; wr_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
      check("reset_stateVal", stateVal, 2'b11);
      check("reset_fields", {varPos1, varPos2, negCtrl1, negCtrl2}, 12'd0);
      check("reset_busy_done_sat", {busy, done, sat}, 3'b000);
      check("reset_clause_cnt", clause_cnt, 6'd0);
      reset = 1'b0;

      wr(5'd0, {1'b0, 1'b0, 5'd3, 1'b1, 5'd2});
      wr(5'd1, {1'b1, 1'b0, 5'd4, 1'b0, 5'd5});
      wr(5'd2, {1'b1, 1'b1, 5'd7, 1'b0, 5'd7});

      expect_main(1'b0);
      run(6'd3, 1'b0, 9, 0);

      expect_main(1'b1);
      run(6'd3, 1'b1, 9, 3);

      push(2'b00); push(2'b11); push(2'b11);
      push(2'b11, 0, 0, 0, 0, 1'b1, 6'd0, 1'b1);
      run(6'd0, 1'b1, 4, 0);

      // Abort during the second LIT.
      push(2'b00);
      push(2'b01, 5'd2, 1'b1, 5'd3, 1'b0);
      push(2'b01, 5'd5, 1'b0, 5'd4, 1'b0);
      outCNF = 1'b1; num_entries = 6'd3; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_pre_state", stateVal, 2'b01);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_stateVal", stateVal, 2'b11);
      check("abort_busy_done", {busy, done}, 2'b00);
      check("abort_clause_cnt", clause_cnt, 6'd0);
      check("abort_sat", sat, 1'b0);
      @(posedge clk); #1;
      check("abort_queue", exp_q.size(), 0);
      exp_q.delete();

      expect_main(1'b1);
      run(6'd3, 1'b1, 9, 0);

      wr(5'd0, {1'b0, 1'b1, 5'd9, 1'b0, 5'd4});
      push(2'b00);
      push(2'b01, 5'd4, 1'b0, 5'd9, 1'b1);
      push(2'b10); push(2'b11); push(2'b11);
      push(2'b11, 0, 0, 0, 0, 1'b1, 6'd1, 1'b0);
      run(6'd1, 1'b0, 6, 0);

      for (int i = 1; i < 32; i++) wr(5'(i), {1'b1, 1'b0, 5'(31 - i), 1'b1, 5'(i)});
      push(2'b00);
      for (int i = 0; i < 32; i++) begin
         push(2'b01, 5'(i), 1'b1, 5'(31 - i), 1'b0);
         push(2'b10);
      end
      push(2'b11); push(2'b11);
      push(2'b11, 0, 0, 0, 0, 1'b1, 6'd32, 1'b1);
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = {1'b1, 1'b0, 5'd31, 1'b1, 5'd0};
      run(6'd40, 1'b1, 68, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
